store_pack: RTL and testbench
=============================

# store_pack

Store-side byte-lane packer and write buffer between the MEM stage and data memory; the write-direction counterpart of the load/immediate extension path. Accepts sb/sh/sw requests (byte address, 32-bit register data, size), narrows data into byte lanes with a 4-bit byte enable and a word-aligned address, and queues packed entries in a small FIFO drained by a valid/ready handshake to data memory.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- st_valid  in  1  store request present
- st_ready  out  1  packer can accept a request
- st_addr  in  32  byte address
- st_data  in  32  register rt value; low bits significant for sb/sh
- st_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- mem_valid  out  1  head entry valid
- mem_ready  in  1  memory accepts head entry
- mem_addr  out  32  word address, bits [1:0]=0
- mem_wdata  out  32  lane-replicated data
- mem_be  out  4  byte enable, bit i = byte lane i
- misalign_err  out  1  one-cycle pulse: rejected misaligned request
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Accept: st_valid && st_ready. st_ready = (count != DEPTH); no pass-through when full, even if a dequeue occurs that cycle.
- Packing of accepted request:
  - byte: wdata = {4{st_data[7:0]}}, be = 4'b0001 << st_addr[1:0]
  - half: wdata = {2{st_data[15:0]}}, be = st_addr[1] ? 4'b1100 : 4'b0011
  - word: wdata = st_data, be = 4'b1111
  - mem_addr = {st_addr[31:2], 2'b00}
- Dequeue: mem_valid && mem_ready; head advances. mem_valid = (count != 0).
- mem_addr/mem_wdata/mem_be present head entry; forced to 0 when empty.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance; legal whenever not full (and when full, only dequeue happens).
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Misaligned or reserved request (see Configuration): consumed by handshake, not enqueued, misalign_err = 1 next cycle.

## Timing
- Reset (reset=0 at edge): pointers 0, count 0, mem_valid 0, mem_addr/wdata/be 0, misalign_err 0, st_ready 1 from the following cycle. Reset mid-operation discards all queued entries.
- Enqueue latency: request accepted at edge N visible on mem_* after edge N (cycle N+1) if FIFO was empty; otherwise behind older entries, strict order.
- misalign_err registered: high exactly the cycle after the offending accept, low otherwise.
- Throughput: one enqueue and one dequeue per cycle.
- mem_* stable while mem_valid && !mem_ready.

## Configuration
- STORE_ALIGN_CHECK_EN defined: half with st_addr[0]=1, word with st_addr[1:0]≠0, or st_size=3 is misaligned → rejected, misalign_err pulses.
- Not defined: no check; half uses st_addr[1] only, word ignores st_addr[1:0], size 3 packed as word; misalign_err tied 0.

## Structure
- Package store_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD, packed entry struct {addr[31:0], wdata[31:0], be[3:0]}.
- Sub-module store_lane_pack: combinational size/offset → wdata/be/aligned-addr/misaligned flag; top holds FIFO, pointers, count, error register.

## Test plan
- sb addr 0x1003 data 0x000000A5, mem_ready=1 → next cycle mem_addr 0x1000, wdata 0xA5A5A5A5, be 4'b1000.
- sh addr 0x2002 data 0x1234BEEF → mem_addr 0x2000, wdata 0xBEEFBEEF, be 4'b1100; sw 0x3000 0xDEADBEEF → be 4'b1111.
- mem_ready=0, three sw with DEPTH=2 → first two accepted, st_ready 0, count 2; release mem_ready → order preserved, count 2→1→0 as third is then accepted.
- Full FIFO with simultaneous st_valid and mem_ready=1 → dequeue only, count 2→1, request accepted next cycle.
- With STORE_ALIGN_CHECK_EN: sw addr 0x4001 → accepted, not enqueued, misalign_err 1 for one cycle, count 0; without macro → enqueued at 0x4000, be 4'b1111.
- Two entries queued, reset=0 one cycle → count 0, mem_valid 0, mem_* 0; next request enqueues at pointer 0.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types for the store packer: size encodings and the packed write-buffer entry.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } st_size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_entry_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational byte-lane packer: size/offset -> replicated wdata, byte enable, word address.
// Alignment checking is present only when STORE_ALIGN_CHECK_EN is defined.
module store_lane_pack
  import store_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  output logic [31:0] waddr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        misaligned_o
);

  always_comb begin
    waddr_o      = {addr_i[31:2], 2'b00};
    wdata_o      = data_i;
    be_o         = 4'b1111;
    misaligned_o = 1'b0;
    unique case (st_size_e'(size_i))
      SZ_BYTE: begin
        wdata_o = {4{data_i[7:0]}};
        be_o    = 4'b0001 << addr_i[1:0];
      end
      SZ_HALF: begin
        wdata_o = {2{data_i[15:0]}};
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_ALIGN_CHECK_EN
        misaligned_o = addr_i[0];
`endif
      end
      SZ_WORD: begin
`ifdef STORE_ALIGN_CHECK_EN
        misaligned_o = (addr_i[1:0] != 2'b00);
`endif
      end
      default: begin
        // Reserved size behaves as a word store unless alignment checking rejects it.
`ifdef STORE_ALIGN_CHECK_EN
        misaligned_o = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/store_pack.sv
// Store packer and write buffer: packs sb/sh/sw requests and queues them toward data memory.
// Optional alignment rejection is enabled by defining STORE_ALIGN_CHECK_EN.
module store_pack
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [1:0]                 st_size,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready. Ready does not
  // depend on valid; a full buffer refuses requests even if the head drains that cycle.
  st_entry_t         fifo_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              misalign_q, misalign_d;

  st_entry_t         new_entry;
  st_entry_t         head;
  logic              misaligned;
  logic              accept, enq, deq;

  store_lane_pack u_lane_pack (
    .addr_i       (st_addr),
    .data_i       (st_data),
    .size_i       (st_size),
    .waddr_o      (new_entry.addr),
    .wdata_o      (new_entry.wdata),
    .be_o         (new_entry.be),
    .misaligned_o (misaligned)
  );

  assign st_ready  = (count_q != CW'(DEPTH));
  assign mem_valid = (count_q != '0);
  assign accept    = st_valid && st_ready;
  assign enq       = accept && !misaligned;
  assign deq       = mem_valid && mem_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = accept && misaligned;
    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage needs no reset: empty-state outputs are masked by mem_valid.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr_q] <= new_entry;
  end

  assign head         = fifo_q[rd_ptr_q];
  assign mem_addr     = mem_valid ? head.addr  : 32'h0;
  assign mem_wdata    = mem_valid ? head.wdata : 32'h0;
  assign mem_be       = mem_valid ? head.be    : 4'h0;
  assign misalign_err = misalign_q;
  assign count        = count_q;

endmodule

// File: tb/tb_store_pack.sv
// Directed bench for store_pack (DEPTH=2); honours STORE_ALIGN_CHECK_EN when defined.
module tb_store_pack;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign_err;
  logic [1:0]  count;

  int n_vec;
  int n_err;

  store_pack #(.DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_size      (st_size),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .misalign_err (misalign_err),
    .count        (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request at a falling edge; returns at the falling edge after the accept edge.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    st_valid = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    check_eq({tag, "_addr"},  mem_addr,  a);
    check_eq({tag, "_wdata"}, mem_wdata, d);
    check_eq({tag, "_be"},    {28'h0, mem_be}, {28'h0, be});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    st_size   = 2'd0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    check_eq("rst_count",    {30'h0, count}, 32'd0);
    check_eq("rst_valid",    {31'h0, mem_valid}, 32'd0);
    check_eq("rst_ready",    {31'h0, st_ready}, 32'd1);
    check_eq("rst_addr",     mem_addr, 32'h0);
    check_eq("rst_misalign", {31'h0, misalign_err}, 32'd0);

    // Single stores with memory ready: visible the cycle after accept, gone the next.
    mem_ready = 1'b1;
    push(32'h0000_1003, 32'h0000_00A5, 2'd0);
    check_eq("sb_valid", {31'h0, mem_valid}, 32'd1);
    check_eq("sb_count", {30'h0, count}, 32'd1);
    check_head("sb", 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
    @(negedge clk);
    check_eq("sb_drained", {30'h0, count}, 32'd0);
    check_eq("empty_wdata", mem_wdata, 32'h0);

    push(32'h0000_2002, 32'h1234_BEEF, 2'd1);
    check_head("sh_hi", 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    @(negedge clk);
    push(32'h0000_3000, 32'hDEAD_BEEF, 2'd2);
    check_head("sw", 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
    @(negedge clk);
    push(32'h0000_1001, 32'hFFFF_FF7E, 2'd0);
    check_head("sb_lane1", 32'h0000_1000, 32'h7E7E_7E7E, 4'b0010);
    @(negedge clk);
    push(32'h0000_2000, 32'h0000_C3D2, 2'd1);
    check_head("sh_lo", 32'h0000_2000, 32'hC3D2_C3D2, 4'b0011);
    @(negedge clk);

    // Backpressure: fill, hold third request, then drain in order.
    mem_ready = 1'b0;
    push(32'h0000_5000, 32'h1111_1111, 2'd2);
    push(32'h0000_5004, 32'h2222_2222, 2'd2);
    check_eq("full_count", {30'h0, count}, 32'd2);
    check_eq("full_ready", {31'h0, st_ready}, 32'd0);
    st_addr  = 32'h0000_5008;
    st_data  = 32'h3333_3333;
    st_size  = 2'd2;
    st_valid = 1'b1;
    @(negedge clk);
    check_eq("hold_count", {30'h0, count}, 32'd2);
    check_head("hold_head", 32'h0000_5000, 32'h1111_1111, 4'b1111);
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("full_deq_only", {30'h0, count}, 32'd1);
    check_head("order_b", 32'h0000_5004, 32'h2222_2222, 4'b1111);
    @(negedge clk);
    st_valid = 1'b0;
    check_eq("enq_deq_count", {30'h0, count}, 32'd1);
    check_head("order_c", 32'h0000_5008, 32'h3333_3333, 4'b1111);
    @(negedge clk);
    check_eq("bp_drained", {30'h0, count}, 32'd0);

    // Misaligned word store.
    mem_ready = 1'b0;
    push(32'h0000_4001, 32'hCAFE_F00D, 2'd2);
`ifdef STORE_ALIGN_CHECK_EN
    check_eq("mis_err",   {31'h0, misalign_err}, 32'd1);
    check_eq("mis_count", {30'h0, count}, 32'd0);
    check_eq("mis_valid", {31'h0, mem_valid}, 32'd0);
    @(negedge clk);
    check_eq("mis_pulse", {31'h0, misalign_err}, 32'd0);
    push(32'h0000_2001, 32'h0000_1234, 2'd1);
    check_eq("mis_half", {31'h0, misalign_err}, 32'd1);
    push(32'h0000_2000, 32'h0000_1234, 2'd3);
    check_eq("mis_rsvd", {31'h0, misalign_err}, 32'd1);
    check_eq("mis_count2", {30'h0, count}, 32'd0);
    @(negedge clk);
`else
    check_eq("mis_err",   {31'h0, misalign_err}, 32'd0);
    check_eq("mis_count", {30'h0, count}, 32'd1);
    check_head("mis_word", 32'h0000_4000, 32'hCAFE_F00D, 4'b1111);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    push(32'h0000_2000, 32'h0000_1234, 2'd3);
    check_head("rsvd_word", 32'h0000_2000, 32'h0000_1234, 4'b1111);
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("rsvd_drained", {30'h0, count}, 32'd0);
    mem_ready = 1'b0;
`endif

    // Reset mid-operation discards queued entries.
    push(32'h0000_7000, 32'hAAAA_AAAA, 2'd2);
    push(32'h0000_7004, 32'hBBBB_BBBB, 2'd2);
    check_eq("pre_rst_count", {30'h0, count}, 32'd2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_eq("mid_rst_count", {30'h0, count}, 32'd0);
    check_eq("mid_rst_valid", {31'h0, mem_valid}, 32'd0);
    check_head("mid_rst", 32'h0, 32'h0, 4'h0);
    check_eq("mid_rst_ready", {31'h0, st_ready}, 32'd1);
    push(32'h0000_6002, 32'h0000_005A, 2'd0);
    check_eq("post_rst_count", {30'h0, count}, 32'd1);
    check_head("post_rst", 32'h0000_6000, 32'h5A5A_5A5A, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
